// File: rtl/gen_fifo_pkg.sv
// rtl/gen_fifo_pkg.sv - shared types and defaults for the generator output FIFO
// Purpose: FSM state encoding and default geometry used by gen_output_fifo and gen_fifo_mem.
// Ports: none (package).
package gen_fifo_pkg;

  typedef enum logic [1:0] {
    FIFO_IDLE  = 2'd0,
    FIFO_RUN   = 2'd1,
    FIFO_DRAIN = 2'd2
  } fifo_state_t;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 4;

endpackage

// File: rtl/gen_fifo_mem.sv
// rtl/gen_fifo_mem.sv - DEPTH x 2*WIDTH register array, one write port, one async read port
// Purpose: tuple storage for gen_output_fifo; cleared on reset so the head reads zero.
// Ports:
//   clk      in   clock
//   resetn   in   synchronous active-low reset (clears every entry)
//   wr_en    in   write strobe
//   wr_addr  in   write index
//   wr_data  in   {element1, element0}
//   rd_addr  in   read index (head pointer)
//   rd_data  out  entry at rd_addr, combinational
module gen_fifo_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [2*WIDTH-1:0]   wr_data,
  input  logic [AW-1:0]        rd_addr,
  output logic [2*WIDTH-1:0]   rd_data
);

  logic [2*WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/gen_output_fifo.sv
// rtl/gen_output_fifo.sv - buffering stage for a generator's ready/valid/done tuple stream
// Purpose: decouples generator stalls from consumer back-pressure with a DEPTH-entry FIFO and
//   re-times the generator's end-of-stream pulse into out_done after the last buffered tuple.
// Optional feature macro: GEN_FIFO_STATS_EN adds the beat_count output (pops since _start).
// Ports:
//   _clock      in   clock
//   _reset      in   synchronous reset, active-low
//   _start      in   new invocation: flush, clear done tracking, enter RUN
//   gen_out0/1  in   generator tuple elements (signed)
//   gen_valid   in   generator tuple valid
//   gen_done    in   generator end-of-stream pulse
//   gen_ready   out  space available while running
//   out0/out1   out  FIFO head tuple
//   out_valid   out  FIFO not empty
//   out_ready   in   consumer ready
//   out_done    out  one-cycle end-of-stream pulse
//   beat_count  out  [GEN_FIFO_STATS_EN] saturating count of delivered tuples
module gen_output_fifo
  import gen_fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                    _clock,
  input  logic                    _reset,
  input  logic                    _start,
  input  logic signed [WIDTH-1:0] gen_out0,
  input  logic signed [WIDTH-1:0] gen_out1,
  input  logic                    gen_valid,
  input  logic                    gen_done,
  output logic                    gen_ready,
  output logic signed [WIDTH-1:0] out0,
  output logic signed [WIDTH-1:0] out1,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_done
`ifdef GEN_FIFO_STATS_EN
  , output logic [31:0]           beat_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fifo_state_t        state, state_next;
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      count;
  logic               done_seen;
  logic               push, pop, drain_exit;
  logic [2*WIDTH-1:0] rd_data;

  // Handshake outputs decode registered state only.
  assign gen_ready = (state == FIFO_RUN) && (count < DEPTH_C);
  assign out_valid = (count != '0);

  // A push coinciding with _start belongs to the stream being abandoned.
  assign push = gen_valid && gen_ready && !_start;
  assign pop  = out_valid && out_ready;

  // End of stream is reported only once the FIFO is empty and the consumer is ready.
  assign drain_exit = (state == FIFO_DRAIN) && done_seen && (count == '0) && out_ready;

  always_comb begin
    state_next = state;
    if (_start) begin
      state_next = FIFO_RUN;
    end else begin
      case (state)
        FIFO_IDLE:  state_next = FIFO_IDLE;
        FIFO_RUN:   if (gen_done) state_next = FIFO_DRAIN;
        FIFO_DRAIN: if (drain_exit) state_next = FIFO_IDLE;
        default:    state_next = FIFO_IDLE;
      endcase
    end
  end

  always_ff @(posedge _clock) begin
    if (!_reset) begin
      state     <= FIFO_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_done  <= 1'b0;
      done_seen <= 1'b0;
    end else begin
      state    <= state_next;
      out_done <= drain_exit && !_start;
      if (_start) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        count     <= '0;
        done_seen <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
        if ((state == FIFO_RUN) && gen_done) done_seen <= 1'b1;
      end
    end
  end

  gen_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (_clock),
    .resetn  (_reset),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data ({gen_out1, gen_out0}),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  assign out0 = rd_data[WIDTH-1:0];
  assign out1 = rd_data[2*WIDTH-1:WIDTH];

`ifdef GEN_FIFO_STATS_EN
  always_ff @(posedge _clock) begin
    if (!_reset || _start) begin
      beat_count <= '0;
    end else if (pop && (beat_count != '1)) begin
      beat_count <= beat_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_gen_output_fifo.sv
// tb/tb_gen_output_fifo.sv - directed self-checking bench for gen_output_fifo
module tb_gen_output_fifo;

  logic               clock = 1'b0;
  logic               reset_n;
  logic               start;
  logic signed [31:0] gen_out0, gen_out1;
  logic               gen_valid, gen_done, gen_ready;
  logic signed [31:0] out0, out1;
  logic               out_valid, out_ready, out_done;
`ifdef GEN_FIFO_STATS_EN
  logic [31:0]        beat_count;
  logic [31:0]        beat_at_done;
`endif

  int   checks = 0;
  int   errors = 0;
  int   pops, dones, valid_cycles, hold_gi;
  logic hold_rdy;

  always #5 clock = ~clock;

  gen_output_fifo #(.WIDTH(32), .DEPTH(4)) dut (
    ._clock     (clock),
    ._reset     (reset_n),
    ._start     (start),
    .gen_out0   (gen_out0),
    .gen_out1   (gen_out1),
    .gen_valid  (gen_valid),
    .gen_done   (gen_done),
    .gen_ready  (gen_ready),
    .out0       (out0),
    .out1       (out1),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_done   (out_done)
`ifdef GEN_FIFO_STATS_EN
    , .beat_count (beat_count)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_cycle(input bit v, input int d, input bit done, input bit rdy);
    gen_valid = v;
    gen_out0  = 32'(d);
    gen_out1  = 32'(d);
    gen_done  = done;
    out_ready = rdy;
    step();
  endtask

  task automatic start_pulse();
    start     = 1'b1;
    gen_valid = 1'b0;
    gen_done  = 1'b0;
    step();
    start     = 1'b0;
  endtask

  // Generator offers 0..n-1 (element 1 optionally -(i+1)), then one gen_done pulse.
  // The consumer holds out_ready low for the first `hold` cycles, then high.
  task automatic run_stream(input int n, input int hold, input bit neg, input int budget);
    int gi;
    bit done_sent;
    logic signed [31:0] e1;
    gi = 0; done_sent = 0;
    pops = 0; dones = 0; valid_cycles = 0; hold_gi = -1; hold_rdy = 1'bx;
    for (int c = 0; c < budget; c++) begin
      if (out_done) begin
        dones++;
        check("done_without_valid", out_valid, 0);
`ifdef GEN_FIFO_STATS_EN
        beat_at_done = beat_count;
`endif
      end
      if (out_valid) valid_cycles++;
      if (c == hold) begin
        hold_gi  = gi;
        hold_rdy = gen_ready;
      end
      out_ready = (c >= hold);
      gen_valid = (gi < n);
      gen_out0  = 32'(gi);
      gen_out1  = neg ? 32'(-(gi + 1)) : 32'(gi);
      gen_done  = (gi == n) && !done_sent;
      if (gen_done) done_sent = 1;
      if (out_valid && out_ready) begin
        e1 = neg ? 32'(-(pops + 1)) : 32'(pops);
        check("out0_order", out0, 32'(pops));
        check("out1_order", out1, e1);
        pops++;
      end
      if (gen_valid && gen_ready) gi++;
      step();
    end
    gen_valid = 1'b0;
    gen_done  = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; gen_valid = 1'b0; gen_done = 1'b0;
    gen_out0 = '0; gen_out1 = '0; out_ready = 1'b0;

    // Reset, with _start asserted during reset (reset wins).
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    check("rst_gen_ready", gen_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out0", out0, 0);
    check("rst_out1", out1, 0);
    check("rst_out_done", out_done, 0);
    reset_n = 1'b1;
    step();
    check("idle_gen_ready", gen_ready, 0);

    // 1: stream 0..9 with consumer always ready.
    start_pulse();
    check("run_gen_ready", gen_ready, 1);
    run_stream(10, 0, 0, 30);
    check("t1_pops", pops, 10);
    check("t1_valid_beats", valid_cycles, 10);
    check("t1_dones", dones, 1);
`ifdef GEN_FIFO_STATS_EN
    check("t6_beat_at_done", beat_at_done, 10);
    start_pulse();
    check("t6_beat_cleared", beat_count, 0);
`endif

    // 2: consumer stalled for 8 cycles; only DEPTH tuples accepted.
    start_pulse();
    run_stream(10, 8, 1, 40);
    check("t2_accepted_while_stalled", hold_gi, 4);
    check("t2_gen_ready_full", hold_rdy, 0);
    check("t2_pops", pops, 10);
    check("t2_dones", dones, 1);

    // 3: gen_done with 3 buffered tuples, out_ready toggling.
    start_pulse();
    drive_cycle(1, 10, 0, 0);
    drive_cycle(1, 11, 0, 0);
    drive_cycle(1, 12, 0, 0);
    check("t3_head0", out0, 10);
    drive_cycle(0, 0, 1, 0);
    check("t3_drain_gen_ready", gen_ready, 0);
    drive_cycle(0, 0, 0, 1);
    check("t3_head1", out0, 11);
    drive_cycle(0, 0, 0, 0);
    check("t3_hold_head1", out0, 11);
    drive_cycle(0, 0, 0, 1);
    check("t3_head2", out0, 12);
    drive_cycle(0, 0, 0, 0);
    drive_cycle(0, 0, 0, 1);
    check("t3_empty", out_valid, 0);
    check("t3_no_done_at_last_pop", out_done, 0);
    drive_cycle(0, 0, 0, 0);
    check("t3_done_held_by_ready", out_done, 0);
    drive_cycle(0, 0, 0, 1);
    check("t3_done_pulse", out_done, 1);
    check("t3_done_valid_low", out_valid, 0);
    drive_cycle(0, 0, 0, 1);
    check("t3_done_one_cycle", out_done, 0);

    // 4: empty stream.
    start_pulse();
    run_stream(0, 0, 0, 10);
    check("t4_valid_never", valid_cycles, 0);
    check("t4_dones", dones, 1);

    // 5: reset mid-stream with 2 buffered tuples, then a fresh stream.
    start_pulse();
    drive_cycle(1, 20, 0, 0);
    drive_cycle(1, 21, 0, 0);
    check("t5_buffered_head", out0, 20);
    reset_n = 1'b0;
    drive_cycle(0, 0, 0, 0);
    reset_n = 1'b1;
    check("t5_rst_out_valid", out_valid, 0);
    check("t5_rst_gen_ready", gen_ready, 0);
    check("t5_rst_out0", out0, 0);
    check("t5_rst_out_done", out_done, 0);
    drive_cycle(0, 0, 1, 0);
    drive_cycle(0, 0, 0, 1);
    check("t5_idle_done_ignored", out_done, 0);
    check("t5_still_idle", gen_ready, 0);
    start_pulse();
    check("t5_restart_ready", gen_ready, 1);
    run_stream(10, 0, 1, 40);
    check("t5_pops", pops, 10);
    check("t5_dones", dones, 1);

    // 7: _start mid-stream flushes and drops the same-edge push.
    start_pulse();
    drive_cycle(1, 30, 0, 0);
    drive_cycle(1, 31, 0, 0);
    start = 1'b1;
    drive_cycle(1, 55, 0, 0);
    start = 1'b0;
    gen_valid = 1'b0;
    check("t7_flushed", out_valid, 0);
    check("t7_ready_after_start", gen_ready, 1);
    drive_cycle(0, 0, 0, 1);
    check("t7_no_spurious_done", out_done, 0);
    run_stream(3, 0, 0, 20);
    check("t7_pops", pops, 3);
    check("t7_dones", dones, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
